riscv_multicycle_ctrl: RTL and testbench

//  Multicycle control FSM for the 8-bit RISC-V teaching datapath shown on the LCD.

---
 rtl/riscv_multicycle_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control FSM for the 8-bit RISC-V teaching datapath.
//
// Sequences fetch / decode / execute for lw, sw, R-type, I-type ALU, beq and jal.
// Progress is gated by a run / single-step control: in free-run the FSM advances
// every cycle, in step mode it advances once per 0->1 edge of the step switch.
//
// Handshake / gating: adv = run | (step & ~step_q) is the single "advance" strobe.
// The state register, instruction counter and illegal flag change only on a
// clock edge where adv = 1 (reset excepted). The write enables are qualified
// with adv and forced low while reset is high, so a held FSM never repeats a
// write. Mux selects and the internal ALUOp are registered Moore outputs that
// are loaded together with the state, so they stay stable while the FSM is held.
// PCWrite, ALUControl and ImmSrc also depend on datapath inputs (zero, funct3,
// funct7b5, op) and are therefore combinational.
module riscv_multicycle_ctrl #(
    parameter int NBITS_TOP = 8
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 Branch,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [2:0]           ALUControl,
    output logic [3:0]           state,
    output logic [NBITS_TOP-1:0] instr_count,
    output logic                 illegal
);

    // ------------------------------------------------------------------
    // Opcodes understood by this datapath
    // ------------------------------------------------------------------
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // FSM state encoding is fixed because the LCD shows the raw code.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    // Per-state Moore outputs. Write-type fields are raw strobes that still
    // have to be qualified by adv before leaving the block.
    typedef struct packed {
        logic       adr_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       pc_update;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } moore_t;

    // Moore output table, evaluated on the state about to be entered so the
    // registered copy always matches the registered state.
    function automatic moore_t moore_of(input state_t s);
        moore_t m;
        m = '0;
        case (s)
            S_FETCH: begin
                m.adr_src    = 1'b0;
                m.ir_write   = 1'b1;
                m.alu_src_b  = 2'b10;
                m.result_src = 2'b10;
                m.pc_update  = 1'b1;
            end
            S_DECODE: begin
                m.alu_src_a = 2'b01;
                m.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                m.alu_src_a = 2'b10;
                m.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                m.adr_src = 1'b1;
            end
            S_MEMWB: begin
                m.result_src = 2'b01;
                m.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                m.adr_src   = 1'b1;
                m.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                m.alu_src_a = 2'b10;
                m.alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                m.alu_src_a = 2'b10;
                m.alu_src_b = 2'b01;
                m.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                m.reg_write = 1'b1;
            end
            S_BEQ: begin
                m.alu_src_a = 2'b10;
                m.alu_op    = 2'b01;
                m.branch    = 1'b1;
            end
            S_JAL: begin
                m.alu_src_a = 2'b01;
                m.alu_src_b = 2'b10;
                m.pc_update = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               state_q;
    state_t               next_state;
    moore_t               mo_q;
    logic                 step_q;
    logic                 adv;
    logic                 wr_en;
    logic                 op_legal;
    logic [NBITS_TOP-1:0] count_q;
    logic                 illegal_q;

    assign adv   = run | (step & ~step_q);
    assign wr_en = adv & ~reset;

    // Opcode is one this FSM knows how to sequence.
    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RTYP, OP_ITYP, OP_BEQ, OP_JAL: op_legal = 1'b1;
            default:                                        op_legal = 1'b0;
        endcase
    end

    // Next-state logic; unused encodings and unknown opcodes fall back to FETCH.
    always_comb begin
        next_state = S_FETCH;
        case (state_q)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYP:      next_state = S_EXECUTER;
                    OP_ITYP:      next_state = S_EXECUTEI;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: next_state = S_FETCH;
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BEQ:      next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // FSM, registered Moore outputs, step edge detector, counter and sticky flag.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q   <= S_FETCH;
            mo_q      <= moore_of(S_FETCH);
            step_q    <= 1'b0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            step_q <= step;
            if (adv) begin
                state_q <= next_state;
                mo_q    <= moore_of(next_state);
                if (state_q == S_FETCH) begin
                    count_q <= count_q + 1'b1;
                end
                if ((state_q == S_DECODE) && !op_legal) begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // ALU control: ALUOp from the state, refined by the instruction fields.
    // ------------------------------------------------------------------
    always_comb begin
        ALUControl = 3'b000;
        case (mo_q.alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_LW, OP_ITYP: ImmSrc = 2'b00;
            OP_SW:          ImmSrc = 2'b01;
            OP_BEQ:         ImmSrc = 2'b10;
            OP_JAL:         ImmSrc = 2'b11;
            default:        ImmSrc = 2'b00;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign PCWrite     = wr_en & (mo_q.pc_update | (mo_q.branch & zero));
    assign IRWrite     = wr_en & mo_q.ir_write;
    assign MemWrite    = wr_en & mo_q.mem_write;
    assign RegWrite    = wr_en & mo_q.reg_write;
    assign Branch      = mo_q.branch;
    assign AdrSrc      = mo_q.adr_src;
    assign ResultSrc   = mo_q.result_src;
    assign ALUSrcA     = mo_q.alu_src_a;
    assign ALUSrcB     = mo_q.alu_src_b;
    assign state       = state_q;
    assign instr_count = count_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed testbench for riscv_multicycle_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are checked in the
// same window, well away from the next rising edge.
module tb_riscv_multicycle_ctrl;

    logic       clk_2;
    logic       reset;
    logic       run;
    logic       step;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       Branch;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;
    logic [7:0] instr_count;
    logic       illegal;

    int vectors;
    int miscompares;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    riscv_multicycle_ctrl #(.NBITS_TOP(8)) dut (
        .clk_2       (clk_2),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .PCWrite     (PCWrite),
        .AdrSrc      (AdrSrc),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .Branch      (Branch),
        .ResultSrc   (ResultSrc),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ImmSrc      (ImmSrc),
        .ALUControl  (ALUControl),
        .state       (state),
        .instr_count (instr_count),
        .illegal     (illegal)
    );

    // Clock
    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset    = 1'b1;
        run      = 1'b1;
        step     = 1'b0;
        op       = OP_RTYP;
        funct3   = 3'b000;
        funct7b5 = 1'b1;
        zero     = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_state",   state, 0);
        check("rst_irwrite", IRWrite, 0);
        check("rst_pcwrite", PCWrite, 0);
        check("rst_count",   instr_count, 0);
        check("rst_illegal", illegal, 0);

        // ---- 1: R-type sub, run mode: 0,1,6,8,0 ----
        reset = 1'b0;
        #1;
        check("r_fetch_irwrite", IRWrite, 1);
        check("r_fetch_pcwrite", PCWrite, 1);
        check("r_fetch_srcb",    ALUSrcB, 2);
        check("r_fetch_result",  ResultSrc, 2);
        check("r_fetch_adrsrc",  AdrSrc, 0);
        tick();
        check("r_decode_state", state, 1);
        check("r_count1",       instr_count, 1);
        check("r_decode_srca",  ALUSrcA, 1);
        check("r_decode_srcb",  ALUSrcB, 1);
        check("r_decode_irw",   IRWrite, 0);
        tick();
        check("r_exec_state",   state, 6);
        check("r_exec_sub",     ALUControl, 3'b001);
        check("r_exec_regw",    RegWrite, 0);
        check("r_exec_srca",    ALUSrcA, 2);
        check("r_exec_srcb",    ALUSrcB, 0);
        funct3 = 3'b111; #1;
        check("r_exec_and", ALUControl, 3'b010);
        funct3 = 3'b110; #1;
        check("r_exec_or", ALUControl, 3'b011);
        funct3 = 3'b010; #1;
        check("r_exec_slt", ALUControl, 3'b101);
        funct3 = 3'b000; funct7b5 = 1'b0; #1;
        check("r_exec_add", ALUControl, 3'b000);
        funct7b5 = 1'b1;
        tick();
        check("r_aluwb_state", state, 8);
        check("r_aluwb_regw",  RegWrite, 1);
        tick();
        check("r_back_fetch", state, 0);
        check("r_fetch_regw", RegWrite, 0);

        // ---- 2: lw 0,1,2,3,4,0 then sw 0,1,2,5,0 ----
        op = OP_LW; #1;
        check("lw_immsrc", ImmSrc, 0);
        tick();
        check("lw_decode", state, 1);
        check("lw_count2", instr_count, 2);
        tick();
        check("lw_memadr", state, 2);
        check("lw_memadr_srca", ALUSrcA, 2);
        check("lw_memadr_srcb", ALUSrcB, 1);
        tick();
        check("lw_memread", state, 3);
        check("lw_memread_adr", AdrSrc, 1);
        check("lw_memread_regw", RegWrite, 0);
        tick();
        check("lw_memwb", state, 4);
        check("lw_memwb_result", ResultSrc, 1);
        check("lw_memwb_regw", RegWrite, 1);
        tick();
        check("lw_back_fetch", state, 0);

        op = OP_SW; #1;
        check("sw_immsrc", ImmSrc, 1);
        tick();
        tick();
        check("sw_memadr", state, 2);
        check("sw_memadr_memw", MemWrite, 0);
        tick();
        check("sw_memwrite", state, 5);
        check("sw_memwrite_memw", MemWrite, 1);
        check("sw_memwrite_adr", AdrSrc, 1);
        tick();
        check("sw_back_fetch", state, 0);
        check("sw_fetch_memw", MemWrite, 0);

        // ---- 3: beq taken / not taken ----
        op = OP_BEQ; zero = 1'b1; #1;
        check("beq_immsrc", ImmSrc, 2);
        tick();
        tick();
        check("beq_state", state, 9);
        check("beq_taken_pcw", PCWrite, 1);
        check("beq_branch", Branch, 1);
        check("beq_aluctl", ALUControl, 3'b001);
        tick();
        check("beq_back_fetch", state, 0);
        zero = 1'b0;
        tick();
        tick();
        check("beq_nt_state", state, 9);
        check("beq_nt_pcw", PCWrite, 0);
        check("beq_nt_branch", Branch, 1);
        tick();
        check("beq_nt_back", state, 0);
        check("beq_count5", instr_count, 5);

        // ---- 4: single-step mode ----
        run = 1'b0; step = 1'b0; op = OP_RTYP;
        tick();
        tick();
        check("step_idle_state", state, 0);
        check("step_idle_irw", IRWrite, 0);
        check("step_idle_pcw", PCWrite, 0);
        check("step_idle_count", instr_count, 5);
        step = 1'b1; #1;
        check("step_edge_irw", IRWrite, 1);
        tick();
        check("step_one_adv", state, 1);
        check("step_count6", instr_count, 6);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("step_held_state", state, 1);
            check("step_held_pcw", PCWrite, 0);
        end
        step = 1'b0;
        tick();
        check("step_low_state", state, 1);
        step = 1'b1;
        tick();
        check("step_to_exec", state, 6);
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        check("step_to_aluwb", state, 8);
        check("step_aluwb_held_regw", RegWrite, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("step_aluwb_hold", state, 8);
            check("step_aluwb_hold_regw", RegWrite, 0);
        end
        step = 1'b0;
        tick();
        check("step_aluwb_low_regw", RegWrite, 0);
        step = 1'b1; #1;
        check("step_aluwb_edge_regw", RegWrite, 1);
        tick();
        check("step_back_fetch", state, 0);
        check("step_count_held", instr_count, 6);
        step = 1'b0;
        run  = 1'b1;

        // ---- 5: illegal opcode, sticky until reset ----
        op = OP_BAD; #1;
        check("bad_immsrc", ImmSrc, 0);
        tick();
        check("bad_decode", state, 1);
        check("bad_not_yet", illegal, 0);
        tick();
        check("bad_to_fetch", state, 0);
        check("bad_illegal", illegal, 1);
        op = OP_ITYP; funct3 = 3'b000; funct7b5 = 1'b1;
        tick();
        check("addi_count8", instr_count, 8);
        tick();
        check("addi_exec", state, 7);
        check("addi_aluctl_add", ALUControl, 3'b000);
        check("addi_srcb", ALUSrcB, 1);
        check("addi_illegal_sticky", illegal, 1);
        tick();
        check("addi_aluwb", state, 8);
        tick();
        check("addi_back", state, 0);
        check("addi_illegal_still", illegal, 1);
        reset = 1'b1;
        tick();
        check("rst2_state", state, 0);
        check("rst2_illegal", illegal, 0);
        check("rst2_count", instr_count, 0);
        check("rst2_irw", IRWrite, 0);
        reset = 1'b0;

        // ---- 6: counter wrap and reset mid-instruction ----
        for (int i = 0; i < 255; i++) begin
            tick();
            tick();
            tick();
            tick();
        end
        check("wrap_state", state, 0);
        check("wrap_count255", instr_count, 255);
        tick();
        check("wrap_count0", instr_count, 0);
        check("wrap_decode", state, 1);
        tick();
        check("midrst_exec", state, 7);
        reset = 1'b1; #1;
        check("midrst_regw_during", RegWrite, 0);
        tick();
        check("midrst_state", state, 0);
        check("midrst_regw", RegWrite, 0);
        tick();
        check("midrst_hold", state, 0);
        check("midrst_regw2", RegWrite, 0);
        reset = 1'b0; #1;
        check("midrst_release_irw", IRWrite, 1);
        tick();
        check("midrst_restart", state, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
